// File: rtl/instruction_encode_loader_pkg.sv
// miniRISC ISA constants shared by the instruction field decoder and the encode loader.
package instruction_encode_loader_pkg;

  typedef enum logic [1:0] {
    FMT_R = 2'd0,
    FMT_I = 2'd1,
    FMT_B = 2'd2,
    FMT_J = 2'd3
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  localparam int OPC_HI    = 31, OPC_LO    = 26;
  localparam int RS_HI     = 25, RS_LO     = 21;
  localparam int RT_HI     = 20, RT_LO     = 16;
  localparam int SHAMT_HI  = 15, SHAMT_LO  = 11;
  localparam int FUNC_HI   = 4,  FUNC_LO   = 0;
  localparam int IMM_HI    = 15, IMM_LO    = 0;
  localparam int LABEL1_HI = 15, LABEL1_LO = 0;
  localparam int LABEL0_HI = 25, LABEL0_LO = 0;

endpackage

// File: rtl/instruction_encode_loader_pack.sv
// Combinational packer: format tag plus decoded fields to one 32-bit miniRISC word.
module instruction_pack
  import instruction_encode_loader_pkg::*;
(
  input  logic [1:0]  fmt,
  input  logic [5:0]  opcode,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  shamt,
  input  logic [4:0]  func,
  input  logic [15:0] imm,
  input  logic [15:0] label1,
  input  logic [25:0] label0,
  output logic [31:0] word
);

  always_comb begin
    word = '0;
    word[OPC_HI:OPC_LO] = opcode;
    case (fmt)
      FMT_R: begin
        word[RS_HI:RS_LO]       = rs;
        word[RT_HI:RT_LO]       = rt;
        word[SHAMT_HI:SHAMT_LO] = shamt;
        word[FUNC_HI:FUNC_LO]   = func;
      end
      FMT_I: begin
        word[RS_HI:RS_LO]   = rs;
        word[RT_HI:RT_LO]   = rt;
        word[IMM_HI:IMM_LO] = imm;
      end
      FMT_B: begin
        word[RS_HI:RS_LO]         = rs;
        word[LABEL1_HI:LABEL1_LO] = label1;
      end
      default: word[LABEL0_HI:LABEL0_LO] = label0;
    endcase
  end

endmodule

// File: rtl/instruction_encode_loader.sv
// Packs field tuples into instruction words and streams them into imem from a base address.
module instruction_encode_loader
  import instruction_encode_loader_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        fmt,
  input  logic [5:0]        opcode,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        shamt,
  input  logic [4:0]        func,
  input  logic [15:0]       imm,
  input  logic [15:0]       label1,
  input  logic [25:0]       label0,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              wrap_err
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, waddr_q, waddr_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic [31:0]         wdata_q, wdata_d, packed_word;
  logic                we_q, we_d, wrap_q, wrap_d, xfer;

  instruction_pack u_pack (
    .fmt(fmt), .opcode(opcode), .rs(rs), .rt(rt), .shamt(shamt), .func(func),
    .imm(imm), .label1(label1), .label0(label0), .word(packed_word)
  );

  assign in_ready = (state_q == ST_LOAD) && (rem_q != '0);
  assign xfer     = in_ready && in_valid;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    wrap_d  = wrap_q;
    we_d    = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        addr_d  = base_addr;
        rem_d   = word_count;
        wrap_d  = 1'b0;
        state_d = (word_count == '0) ? ST_FIN : ST_LOAD;
      end
      ST_LOAD: if (xfer) begin
        we_d    = 1'b1;
        waddr_d = addr_q;
        wdata_d = packed_word;
        addr_d  = addr_q + 1'b1;
        rem_d   = rem_q - 1'b1;
        // Only a wrap with words still to come is an error; ending on the top address is fine.
        if ((&addr_q) && (rem_q != CNT_W'(1))) wrap_d = 1'b1;
        if (rem_q == CNT_W'(1)) state_d = ST_FIN;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      wrap_q  <= wrap_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = waddr_q;
  assign imem_wdata = wdata_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_FIN);
  assign wrap_err   = wrap_q;

endmodule

// File: tb/tb_instruction_encode_loader.sv
// Directed bench for instruction_encode_loader with hand-computed instruction words.
module tb_instruction_encode_loader;

  localparam int ADDR_W = 10;
  localparam int CNT_W  = 11;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [CNT_W-1:0]  word_count = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [1:0]        fmt = '0;
  logic [5:0]        opcode = '0;
  logic [4:0]        rs = '0, rt = '0, shamt = '0, func = '0;
  logic [15:0]       imm = '0, label1 = '0;
  logic [25:0]       label0 = '0;
  logic              imem_we, busy, done, wrap_err;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  int vectors = 0;
  int miscompares = 0;

  instruction_encode_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .word_count(word_count),
    .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt), .opcode(opcode), .rs(rs), .rt(rt),
    .shamt(shamt), .func(func), .imm(imm), .label1(label1), .label0(label0),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .wrap_err(wrap_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic fields(input logic [1:0] f, input logic [5:0] o, input logic [4:0] s,
                        input logic [4:0] t, input logic [4:0] sh, input logic [4:0] fn,
                        input logic [15:0] im, input logic [15:0] l1, input logic [25:0] l0);
    fmt = f; opcode = o; rs = s; rt = t; shamt = sh; func = fn; imm = im; label1 = l1; label0 = l0;
  endtask

  task automatic exp_wr(input string tag, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                        input logic dn);
    chk({tag, "_we"},   32'(imem_we), 32'd1);
    chk({tag, "_addr"}, 32'(imem_addr), 32'(a));
    chk({tag, "_data"}, imem_wdata, d);
    chk({tag, "_done"}, 32'(done), 32'(dn));
  endtask

  task automatic go(input logic [ADDR_W-1:0] b, input logic [CNT_W-1:0] n);
    base_addr = b; word_count = n; start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_wrap", 32'(wrap_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick;

    // in_valid in IDLE is ignored
    in_valid = 1'b1;
    fields(2'd0, 6'd1, 5'd1, 5'd1, 5'd1, 5'd1, 16'h0, 16'h0, 26'h0);
    chk("idle_ready", 32'(in_ready), 32'd0);
    tick;
    chk("idle_we", 32'(imem_we), 32'd0);
    in_valid = 1'b0;

    // R-type single word, round trip through the field positions
    go(10'h000, 11'd1);
    chk("r_busy", 32'(busy), 32'd1);
    fields(2'd0, 6'd0, 5'd3, 5'd4, 5'd2, 5'd5, 16'hAAAA, 16'h5555, 26'h1234567);
    in_valid = 1'b1;
    chk("r_ready", 32'(in_ready), 32'd1);
    tick;
    in_valid = 1'b0;
    exp_wr("r", 10'h000, 32'h00641005, 1'b1);
    chk("r_dec_rs", 32'(imem_wdata[25:21]), 32'd3);
    chk("r_dec_rt", 32'(imem_wdata[20:16]), 32'd4);
    chk("r_dec_sh", 32'(imem_wdata[15:11]), 32'd2);
    chk("r_dec_fn", 32'(imem_wdata[4:0]), 32'd5);
    tick;
    chk("r_we_off", 32'(imem_we), 32'd0);
    chk("r_done_off", 32'(done), 32'd0);
    chk("r_idle", 32'(busy), 32'd0);

    // four formats back-to-back
    go(10'h010, 11'd4);
    in_valid = 1'b1;
    fields(2'd1, 6'h01, 5'd1, 5'd2, 5'd31, 5'd31, 16'hFFFF, 16'hFFFF, 26'h3FFFFFF);
    tick;
    exp_wr("b2b0", 10'h010, 32'h0422FFFF, 1'b0);
    fields(2'd2, 6'h0C, 5'd7, 5'd31, 5'd31, 5'd31, 16'hFFFF, 16'h0008, 26'h3FFFFFF);
    tick;
    exp_wr("b2b1", 10'h011, 32'h30E00008, 1'b0);
    fields(2'd3, 6'h10, 5'd31, 5'd31, 5'd31, 5'd31, 16'hFFFF, 16'hFFFF, 26'h3FFFFFF);
    tick;
    exp_wr("b2b2", 10'h012, 32'h43FFFFFF, 1'b0);
    fields(2'd0, 6'h00, 5'd1, 5'd2, 5'd3, 5'd31, 16'hFFFF, 16'hFFFF, 26'h3FFFFFF);
    tick;
    exp_wr("b2b3", 10'h013, 32'h0022181F, 1'b1);
    chk("b2b3_ready", 32'(in_ready), 32'd0);
    tick;
    chk("b2b_we_off", 32'(imem_we), 32'd0);
    in_valid = 1'b0;

    // valid gaps, plus a start while busy that must be ignored
    go(10'h100, 11'd3);
    for (int i = 0; i < 3; i++) begin
      fields(2'd1, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 16'(i + 1), 16'h0, 26'h0);
      in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      exp_wr($sformatf("gap%0d", i), 10'(10'h100 + i), 32'h08000000 | 32'(i + 1), i == 2);
      chk($sformatf("gap%0d_ready", i), 32'(in_ready), (i == 2) ? 32'd0 : 32'd1);
      if (i == 0) begin base_addr = 10'h300; word_count = 11'd0; start = 1'b1; end
      tick;
      start = 1'b0;
      chk($sformatf("gap%0d_we_off", i), 32'(imem_we), 32'd0);
    end
    chk("gap_idle", 32'(busy), 32'd0);

    // zero count
    go(10'h055, 11'd0);
    chk("zero_busy", 32'(busy), 32'd1);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_we", 32'(imem_we), 32'd0);
    chk("zero_ready", 32'(in_ready), 32'd0);
    tick;
    chk("zero_busy_off", 32'(busy), 32'd0);
    chk("zero_done_off", 32'(done), 32'd0);

    // address wrap
    go(10'h3FE, 11'd3);
    in_valid = 1'b1;
    fields(2'd3, 6'h3F, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 16'h0, 26'h0000001);
    tick;
    exp_wr("wrap0", 10'h3FE, 32'hFC000001, 1'b0);
    chk("wrap0_err", 32'(wrap_err), 32'd0);
    tick;
    exp_wr("wrap1", 10'h3FF, 32'hFC000001, 1'b0);
    chk("wrap1_err", 32'(wrap_err), 32'd1);
    tick;
    in_valid = 1'b0;
    exp_wr("wrap2", 10'h000, 32'hFC000001, 1'b1);
    chk("wrap2_err", 32'(wrap_err), 32'd1);
    tick;
    chk("wrap_sticky", 32'(wrap_err), 32'd1);
    go(10'h3FF, 11'd1);
    chk("wrap_clear", 32'(wrap_err), 32'd0);
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    exp_wr("top_end", 10'h3FF, 32'hFC000001, 1'b1);
    chk("top_end_err", 32'(wrap_err), 32'd0);
    tick;

    // reset in the middle of a 5-word load
    go(10'h020, 11'd5);
    in_valid = 1'b1;
    fields(2'd1, 6'h05, 5'd1, 5'd1, 5'd0, 5'd0, 16'h1234, 16'h0, 26'h0);
    tick;
    tick;
    exp_wr("mid1", 10'h021, 32'h14211234, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", 32'(imem_we), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_addr", 32'(imem_addr), 32'd0);
    chk("mid_rst_wdata", imem_wdata, 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick;
      chk($sformatf("mid_hold%0d_done", i), 32'(done), 32'd0);
      chk($sformatf("mid_hold%0d_we", i), 32'(imem_we), 32'd0);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick;
    chk("post_rst_idle", 32'(busy), 32'd0);
    go(10'h040, 11'd1);
    fields(2'd2, 6'h04, 5'd2, 5'd0, 5'd0, 5'd0, 16'h0, 16'hFFFE, 26'h0);
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    exp_wr("post_rst", 10'h040, 32'h1040FFFE, 1'b1);
    tick;
    chk("post_rst_we_off", 32'(imem_we), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
